pkt_fifo_ctrl: RTL and testbench
================================

PKT_FIFO_CTRL -- requirements
Module: pkt_fifo_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, payload bits per beat.
REQ-002 SHALL have parameter AWIDTH, default 8, packet-memory address bits; DEPTH = 2**AWIDTH words.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream beat valid.
REQ-006 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  in  DWIDTH  beat payload.
REQ-008 SHALL have port in_last  in  1  final beat of packet.
REQ-009 SHALL have port in_err  in  1  packet bad; sampled with in_last.
REQ-010 SHALL have port out_valid  out  1  beat available to MAC tx.
REQ-011 SHALL have port out_ready  in  1  MAC tx consumes beat.
REQ-012 SHALL have port out_data  out  DWIDTH  beat payload.
REQ-013 SHALL have port out_last  out  1  final beat of packet.
REQ-014 SHALL have ports f0_waddr out AWIDTH, f0_wdata out DWIDTH+1, f0_write out 1: memory write port; memory writes on the next clk edge.
REQ-015 SHALL have ports f0_raddr out AWIDTH, f0_rdata in DWIDTH+1: memory read port; f0_rdata is combinational from f0_raddr.
REQ-016 SHALL have port pkt_count  out  AWIDTH+1  committed, unread packets.
REQ-017 SHALL have port drop_pulse  out  1  one-cycle pulse per dropped packet.

Function
REQ-018 SHALL hold pointers wr_ptr, commit_ptr, rd_ptr, each AWIDTH+1 bits, wrapping modulo 2**(AWIDTH+1); memory address = low AWIDTH bits.
REQ-019 SHALL store each beat as f0_wdata = {in_last, in_data} at wr_ptr, with f0_write = in_valid && in_ready && state==WRITE, combinationally driven; wr_ptr increments on that beat.
REQ-020 SHALL define used = wr_ptr - rd_ptr and full = (used == DEPTH); in_ready = !full in WRITE, 1 in DISCARD.
REQ-021 SHALL use FSM states WRITE and DISCARD; reset state WRITE.
REQ-022 On accepted beat with in_last=1 and in_err=0 in WRITE: commit_ptr <= wr_ptr+1 and pkt_count increments (store-and-forward; read side sees only complete packets).
REQ-023 On accepted beat with in_last=1 and in_err=1 in WRITE: wr_ptr <= commit_ptr, no write of that beat required to land, drop_pulse=1 next cycle.
REQ-024 When full in WRITE with commit_ptr == rd_ptr (packet exceeds DEPTH): go to DISCARD, wr_ptr <= commit_ptr.
REQ-025 In DISCARD: accept and drop all beats, no memory writes; on accepted in_last go to WRITE and pulse drop_pulse once.
REQ-026 SHALL drive f0_raddr = rd_ptr[AWIDTH-1:0]; out_valid = (rd_ptr != commit_ptr); {out_last, out_data} = f0_rdata; zero latency from rd_ptr change.
REQ-027 On out_valid && out_ready: rd_ptr increments; if out_last then pkt_count decrements.
REQ-028 Commit and read-of-last in same cycle: pkt_count unchanged.
REQ-029 A commit becomes visible to out_valid the cycle after the last beat's write edge, so a word is never read before written.
REQ-030 SHALL hold out_data stable while out_valid && !out_ready.
REQ-031 Freed space from a read is usable by in_ready the following cycle.

Reset
REQ-032 On rst=1 at a clk edge: all pointers 0, pkt_count 0, state WRITE, drop_pulse 0; next cycle out_valid 0, in_ready 1, f0_write 0.
REQ-033 rst mid-packet SHALL discard all stored and partial packets; no beat of a pre-reset packet appears after reset.

Verification
REQ-034 3-beat packet A,B,C(last), err=0, out_ready=1 -> f0_write on 3 cycles, out_valid rises cycle after C accepted, outputs A,B,C with out_last only on C, pkt_count 1->0.
REQ-035 2-beat packet with in_err=1 on last, then 1-beat packet D -> drop_pulse once, only D emitted, wr_ptr rewinds to 0 before D written.
REQ-036 AWIDTH=2, out_ready=0, two 2-beat packets -> in_ready=0 after 4 beats, pkt_count=2; one read -> in_ready=1 next cycle.
REQ-037 AWIDTH=2, 6-beat packet into empty FIFO -> DISCARD after 4 beats, remaining beats accepted, drop_pulse once, out_valid never 1.
REQ-038 Pointer wrap: stream 40 one-beat packets with AWIDTH=2, random out_ready -> data order preserved, no loss, pkt_count never exceeds 4.
REQ-039 rst asserted mid-packet with one committed packet stored -> out_valid 0 and pkt_count 0 cycle after reset; next packet emitted correctly.

Source files
------------

// File: rtl/pkt_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// PktFifoCtrl : store-and-forward packet FIFO controller
//
// Sits between an upstream packet source and a MAC transmitter and manages
// an external single-clock packet memory. Beats are written at wr_ptr as
// they arrive. They become readable only once the whole packet has arrived
// without error, at which point commit_ptr advances past it. Bad packets
// (in_err on the last beat) and packets larger than the whole memory are
// dropped, and each drop raises drop_pulse for one cycle.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_data, in_last, in_err payload
//   out_valid/out_ready  downstream handshake; out_data, out_last payload
//   f0_waddr/f0_wdata/f0_write  memory write port (write lands on next edge)
//   f0_raddr/f0_rdata    memory read port (combinational read)
//   pkt_count            committed packets not yet fully read
//   drop_pulse           one-cycle pulse per dropped packet
// ---------------------------------------------------------------------------
module pkt_fifo_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [AWIDTH-1:0] f0_waddr,
    output logic [DWIDTH:0]   f0_wdata,
    output logic              f0_write,
    output logic [AWIDTH-1:0] f0_raddr,
    input  logic [DWIDTH:0]   f0_rdata,
    output logic [AWIDTH:0]   pkt_count,
    output logic              drop_pulse
);

    // One extra pointer bit tells a completely full memory apart from an
    // empty one when the address bits are equal.
    localparam logic [AWIDTH:0] DepthWords = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic {
        WRITE   = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [AWIDTH:0] wrPtr_q, wrPtr_d;
    logic [AWIDTH:0] commitPtr_q, commitPtr_d;
    logic [AWIDTH:0] rdPtr_q, rdPtr_d;
    logic [AWIDTH:0] pktCount_q, pktCount_d;
    logic            dropPulse_q, dropPulse_d;

    logic [AWIDTH:0] usedWords;
    logic            full;
    logic            inFire;
    logic            outFire;
    logic            commitEvt;
    logic            readLastEvt;
    logic            oversize;

    assign usedWords   = wrPtr_q - rdPtr_q;
    assign full        = (usedWords == DepthWords);
    assign inFire      = in_valid && in_ready;
    assign outFire     = out_valid && out_ready;
    // Memory is full and all of it belongs to the packet still arriving:
    // no amount of reading can make room, so the packet has to be dropped.
    assign oversize    = full && (commitPtr_q == rdPtr_q);
    assign commitEvt   = f0_write && in_last && !in_err;
    assign readLastEvt = outFire && out_last;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WRITE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WRITE:   if (oversize)           state_d = DISCARD;
            DISCARD: if (inFire && in_last)  state_d = WRITE;
            default:                         state_d = WRITE;
        endcase
    end

    // FSM outputs. In DISCARD beats are swallowed without touching memory,
    // so upstream is never stalled there.
    always_comb begin
        in_ready = 1'b1;
        f0_write = 1'b0;
        if (state_q == WRITE) begin
            in_ready = !full;
            f0_write = inFire;
        end
    end

    // Pointer, packet-count and drop bookkeeping. A bad packet rewinds the
    // write pointer to the last commit point so its beats are overwritten by
    // the next packet.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        commitPtr_d = commitPtr_q;
        dropPulse_d = 1'b0;
        if (state_q == WRITE) begin
            if (f0_write) begin
                if (in_last && in_err) begin
                    wrPtr_d     = commitPtr_q;
                    dropPulse_d = 1'b1;
                end else begin
                    wrPtr_d = wrPtr_q + 1'b1;
                    if (in_last) begin
                        commitPtr_d = wrPtr_q + 1'b1;
                    end
                end
            end else if (oversize) begin
                wrPtr_d = commitPtr_q;
            end
        end else if (inFire && in_last) begin
            dropPulse_d = 1'b1;
        end

        rdPtr_d = rdPtr_q + {{AWIDTH{1'b0}}, outFire};

        pktCount_d = pktCount_q;
        case ({commitEvt, readLastEvt})
            2'b10:   pktCount_d = pktCount_q + 1'b1;
            2'b01:   pktCount_d = pktCount_q - 1'b1;
            default: pktCount_d = pktCount_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            pktCount_q  <= '0;
            dropPulse_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            pktCount_q  <= pktCount_d;
            dropPulse_q <= dropPulse_d;
        end
    end

    // Memory ports. The read side only ever looks below commit_ptr, so a word
    // is always written before it is presented.
    assign f0_waddr             = wrPtr_q[AWIDTH-1:0];
    assign f0_wdata             = {in_last, in_data};
    assign f0_raddr             = rdPtr_q[AWIDTH-1:0];
    assign out_valid            = (rdPtr_q != commitPtr_q);
    assign {out_last, out_data} = f0_rdata;
    assign pkt_count            = pktCount_q;
    assign drop_pulse           = dropPulse_q;

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// TbPktFifoCtrl : testbench for pkt_fifo_ctrl with a 4-word packet memory.
//
// Packets are pushed into a packet-level model as they are accepted: good
// packets that fit in memory go beat by beat into an expected-output queue,
// and bad or oversize packets only count as expected drops. A separate
// monitor compares the DUT outputs against that queue every cycle.
// ---------------------------------------------------------------------------
module tb_pkt_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_err;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW-1:0] f0_waddr;
    logic [DW:0]   f0_wdata;
    logic          f0_write;
    logic [AW-1:0] f0_raddr;
    logic [DW:0]   f0_rdata;
    logic [AW:0]   pkt_count;
    logic          drop_pulse;

    int testsRun      = 0;
    int testsFailed   = 0;

    logic [DW:0] expQ[$];
    int commitsIssued  = 0;
    int lastsRead      = 0;
    int dropsExpected  = 0;
    int dropsSeen      = 0;
    int wordsCommitted = 0;
    int readyMode      = 1;
    bit monitorOn      = 1'b0;

    pkt_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_err     (in_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .f0_waddr   (f0_waddr),
        .f0_wdata   (f0_wdata),
        .f0_write   (f0_write),
        .f0_raddr   (f0_raddr),
        .f0_rdata   (f0_rdata),
        .pkt_count  (pkt_count),
        .drop_pulse (drop_pulse)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // External packet memory: synchronous write, combinational read.
    logic [DW:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (f0_write) mem[f0_waddr] <= f0_wdata;
    end
    assign f0_rdata = mem[f0_raddr];

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream ready: held low, held high or random, chosen by readyMode.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    // Monitor: output validity, beat content/order, packet count and drop
    // pulses are all checked against the model state once per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!rst && monitorOn) begin
                checkOutput("pkt_count", 32'(pkt_count), 32'(commitsIssued - lastsRead));
                checkOutput("pkt_count_bound", 32'(pkt_count <= DEPTH), 32'd1);
                if (drop_pulse) dropsSeen++;
                checkOutput("drop_pulses", 32'(dropsSeen), 32'(dropsExpected));
                checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
                if (out_valid && expQ.size() != 0) begin
                    checkOutput("out_beat", 32'({out_last, out_data}), 32'(expQ[0]));
                    if (out_ready) begin
                        if (expQ[0][DW]) lastsRead++;
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset the DUT and the model together, then check the post-reset state.
    task automatic resetDut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_err    = 1'b0;
        monitorOn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        commitsIssued  = 0;
        lastsRead      = 0;
        dropsExpected  = 0;
        dropsSeen      = 0;
        wordsCommitted = 0;
        monitorOn      = 1'b1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("rst_f0_write", 32'(f0_write), 32'd0);
        checkOutput("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    endtask

    // Send one packet of len beats; abortAfter >= 0 stops after that many
    // beats without a last beat. Called just after a rising edge.
    task automatic applyStimulus(input int len, input bit err, input int gapPct,
                                 input int abortAfter);
        logic [DW:0] curPkt[$];
        for (int i = 0; i < len; i++) begin
            int waitCyc;
            bit accepted;
            if (i == abortAfter) begin
                in_valid = 1'b0;
                return;
            end
            waitCyc  = 0;
            accepted = 1'b0;
            while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = (i == len - 1);
            in_err   = err && (i == len - 1);
            while (!accepted) begin
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1'b1;
                    curPkt.push_back({in_last, in_data});
                    if (!(in_last && in_err)) begin
                        checkOutput("f0_write", 32'(f0_write), 32'(i < DEPTH));
                        if (i < DEPTH)
                            checkOutput("f0_waddr", 32'(f0_waddr),
                                        32'((wordsCommitted + i) % DEPTH));
                    end
                    if (in_last) begin
                        if (err || len > DEPTH) begin
                            dropsExpected++;
                        end else begin
                            foreach (curPkt[k]) expQ.push_back(curPkt[k]);
                            commitsIssued++;
                            wordsCommitted += len;
                        end
                    end
                end
                @(posedge clk);
                #1;
                if (!accepted) begin
                    waitCyc++;
                    if (waitCyc > 300) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL accept_timeout: beat %0d still not accepted after %0d cycles, expected acceptance", i, waitCyc);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
    endtask

    // Wait (bounded) until every expected beat has been emitted.
    task automatic waitDrain();
        int cyc = 0;
        while (expQ.size() != 0 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int dropsBefore;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        @(posedge clk);
        #1;
        resetDut();

        // Three-beat good packet streamed straight through.
        readyMode = 1;
        applyStimulus(3, 1'b0, 0, -1);
        waitDrain();

        // Bad two-beat packet, then a one-beat packet reusing its space.
        dropsBefore = dropsExpected;
        applyStimulus(2, 1'b1, 0, -1);
        applyStimulus(1, 1'b0, 0, -1);
        waitDrain();
        checkOutput("err_drops", 32'(dropsExpected - dropsBefore), 32'd1);

        // Fill memory with two packets while downstream stalls.
        readyMode = 0;
        applyStimulus(2, 1'b0, 0, -1);
        applyStimulus(2, 1'b0, 0, -1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_pkt_count", 32'(pkt_count), 32'd2);
        readyMode = 1;
        @(posedge clk);
        #1;
        readyMode = 0;
        #3;
        checkOutput("freed_in_ready", 32'(in_ready), 32'd1);
        readyMode = 1;
        waitDrain();

        // Oversize packet into an empty memory is dropped entirely.
        dropsBefore = dropsSeen;
        applyStimulus(6, 1'b0, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("oversize_drops", 32'(dropsSeen - dropsBefore), 32'd1);

        // Pointer wrap: many one-beat packets with random backpressure.
        readyMode = 2;
        for (int n = 0; n < 40; n++) applyStimulus(1, 1'b0, 30, -1);
        waitDrain();

        // Random mix of lengths and errors.
        for (int n = 0; n < 40; n++)
            applyStimulus($urandom_range(1, 6), ($urandom_range(0, 4) == 0), 20, -1);
        readyMode = 1;
        waitDrain();

        // Reset with one packet stored and another half-written.
        readyMode = 0;
        applyStimulus(2, 1'b0, 0, -1);
        applyStimulus(3, 1'b0, 0, 1);
        resetDut();
        repeat (3) @(posedge clk);
        #1;
        readyMode = 1;
        applyStimulus(3, 1'b0, 0, -1);
        waitDrain();

        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
